// File: rtl/byte_sram_pkg.sv
// rtl/byte_sram_pkg.sv - shared types and lane helpers for the byte-addressed scratch SRAM
//
// Purpose: FSM state type plus pure functions for lane rotation, split
// detection and lane masks. The functions work on a fixed maximum lane
// count; callers zero-extend into and truncate out of the wide vectors.
// Ports: none (package).

package byte_sram_pkg;

  typedef enum logic {ST_IDLE, ST_BEAT2} state_t;

  localparam int MAX_LANES = 32;
  localparam int MAX_BITS  = MAX_LANES * 8;

  // Rotate the low `lanes` lanes (each `lane_w` bits, lane_w <= 8) toward
  // higher lane numbers by `sh`: result lane (i+sh)%lanes = input lane i.
  // Used with lane_w=8 for data and lane_w=1 for strobes.
  function automatic logic [MAX_BITS-1:0] lane_rotate(input logic [MAX_BITS-1:0] data,
                                                      input int lanes,
                                                      input int lane_w,
                                                      input int sh);
    logic [MAX_BITS-1:0] res;
    logic [7:0]          src;
    logic [7:0]          dst;
    res = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (i < lanes && b < lane_w) begin
          src      = 8'(i * lane_w + b);
          dst      = 8'(((i + sh) % lanes) * lane_w + b);
          res[dst] = data[src];
        end
      end
    end
    return res;
  endfunction

  // Reads split whenever misaligned; writes split only if a set strobe lane
  // spills past the end of the first word.
  function automatic logic needs_split(input logic we,
                                       input int off,
                                       input logic [MAX_LANES-1:0] wstrb,
                                       input int lanes);
    logic split;
    split = 1'b0;
    if (!we) begin
      split = (off != 0);
    end else begin
      for (int i = 0; i < MAX_LANES; i++) begin
        if (i < lanes && wstrb[i] && (off + i) >= lanes) split = 1'b1;
      end
    end
    return split;
  endfunction

  // Word lanes at or above the byte offset, i.e. the lanes owned by beat 1.
  function automatic logic [MAX_LANES-1:0] upper_lanes(input int off, input int lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes && i >= off) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/byte_sram_bank.sv
// rtl/byte_sram_bank.sv - DEPTH x DATA_BYTES byte-lane storage with per-lane write enable
//
// Purpose: word-organised byte storage. One shared address per cycle; each
// lane writes when its enable is set; a read registers the whole word and
// the read register holds its value on cycles without a read.
// Ports:
//   clk      in   clock, rising edge
//   i_addr   in   word address
//   i_ren    in   read enable (registers the addressed word)
//   i_wen    in   per-lane write enable
//   i_wdata  in   write data, lane g in bits [8g+7:8g]
//   o_rdata  out  registered read word

module byte_sram_bank #(
  parameter int DATA_BYTES = 4,
  parameter int AW         = 14,
  parameter int DEPTH      = 16384
) (
  input  logic                    clk,
  input  logic [AW-1:0]           i_addr,
  input  logic                    i_ren,
  input  logic [DATA_BYTES-1:0]   i_wen,
  input  logic [8*DATA_BYTES-1:0] i_wdata,
  output logic [8*DATA_BYTES-1:0] o_rdata
);

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_wen[g]) r_mem[i_addr] <= i_wdata[8*g +: 8];
      if (i_ren)    r_q           <= r_mem[i_addr];
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/byte_sram_ctrl.sv
// rtl/byte_sram_ctrl.sv - byte-addressed scratch SRAM with misaligned split access
//
// Purpose: valid/ready request port in front of a byte-lane bank. Aligned or
// in-word accesses take one beat; accesses spilling into the next word take
// two beats (IDLE -> BEAT2). Response is a one-cycle pulse.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   req_valid, req_ready       request handshake
//   req_we, req_addr           write flag, byte address of lane 0
//   req_wstrb, req_wdata       per-lane write strobe and data
//   resp_valid, resp_rdata     response pulse and read data (0 for writes)

module byte_sram_ctrl
  import byte_sram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_BYTES-1:0]   req_wstrb,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [8*DATA_BYTES-1:0] resp_rdata
);

  localparam int LB    = $clog2(DATA_BYTES);
  localparam int DEPTH = (2 ** ADDR_W) / DATA_BYTES;
  localparam int WA    = ADDR_W - LB;
  localparam int DW    = 8 * DATA_BYTES;

  state_t r_state;
  state_t w_next;

  logic [LB-1:0]         w_off;
  logic [WA-1:0]         w_w0;
  logic [WA-1:0]         w_w1;
  logic                  w_accept;
  logic                  w_split;
  logic [DW-1:0]         w_wdata_rot;
  logic [DATA_BYTES-1:0] w_wstrb_rot;
  logic [DATA_BYTES-1:0] w_hi;
  logic [DATA_BYTES-1:0] w_r_hi;

  logic [LB-1:0]         r_off;
  logic [WA-1:0]         r_w1;
  logic                  r_we;
  logic [DW-1:0]         r_wdata_rot;
  logic [DATA_BYTES-1:0] r_wstrb_rot;
  logic [DW-1:0]         r_cap;
  logic                  r_resp_valid;
  logic                  r_resp_rd;
  logic                  r_resp_split;
  logic [DW-1:0]         r_hold;

  logic [WA-1:0]         w_bank_addr;
  logic                  w_bank_ren;
  logic [DATA_BYTES-1:0] w_bank_wen;
  logic [DW-1:0]         w_bank_wdata;
  logic [DW-1:0]         w_bank_rdata;

  logic [DW-1:0]         w_merge;
  logic [DW-1:0]         w_rd_rot;
  logic [DW-1:0]         w_resp_data;

  assign w_off    = req_addr[LB-1:0];
  assign w_w0     = req_addr[ADDR_W-1:LB];
  assign w_w1     = w_w0 + WA'(1);        // wraps modulo DEPTH
  assign w_accept = req_valid && req_ready;
  assign w_split  = needs_split(req_we, int'(w_off), MAX_LANES'(req_wstrb), DATA_BYTES);

  // Request lane i lands on word lane (i+off)%DATA_BYTES; lanes >= off
  // belong to w0, the wrapped ones below off belong to w1.
  assign w_wdata_rot = DW'(lane_rotate(MAX_BITS'(req_wdata), DATA_BYTES, 8, int'(w_off)));
  assign w_wstrb_rot = DATA_BYTES'(lane_rotate(MAX_BITS'(req_wstrb), DATA_BYTES, 1, int'(w_off)));
  assign w_hi        = DATA_BYTES'(upper_lanes(int'(w_off), DATA_BYTES));
  assign w_r_hi      = DATA_BYTES'(upper_lanes(int'(r_off), DATA_BYTES));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_split) w_next = ST_BEAT2;
      ST_BEAT2: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM: outputs and bank control
  always_comb begin
    req_ready    = (r_state == ST_IDLE);
    w_bank_addr  = w_w0;
    w_bank_ren   = 1'b0;
    w_bank_wen   = '0;
    w_bank_wdata = w_wdata_rot;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_we) w_bank_wen = w_wstrb_rot & w_hi;
          else        w_bank_ren = 1'b1;
        end
      end
      ST_BEAT2: begin
        w_bank_addr  = r_w1;
        w_bank_wdata = r_wdata_rot;
        if (r_we) w_bank_wen = r_wstrb_rot & ~w_r_hi;
        else      w_bank_ren = 1'b1;
      end
      default: ;
    endcase
  end

  byte_sram_bank #(
    .DATA_BYTES (DATA_BYTES),
    .AW         (WA),
    .DEPTH      (DEPTH)
  ) u_bank (
    .clk     (clk),
    .i_addr  (w_bank_addr),
    .i_ren   (w_bank_ren),
    .i_wen   (w_bank_wen),
    .i_wdata (w_bank_wdata),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off        <= '0;
      r_w1         <= '0;
      r_we         <= 1'b0;
      r_wdata_rot  <= '0;
      r_wstrb_rot  <= '0;
      r_cap        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rd    <= 1'b0;
      r_resp_split <= 1'b0;
      r_hold       <= '0;
    end else begin
      if (w_accept) begin
        r_off       <= w_off;
        r_w1        <= w_w1;
        r_we        <= req_we;
        r_wdata_rot <= w_wdata_rot;
        r_wstrb_rot <= w_wstrb_rot;
      end
      // Beat-1 word arrives from the bank during BEAT2; keep it for the merge.
      if (r_state == ST_BEAT2) r_cap <= w_bank_rdata;
      r_resp_valid <= (w_accept && !w_split) || (r_state == ST_BEAT2);
      if (r_state == ST_BEAT2) begin
        r_resp_rd    <= !r_we;
        r_resp_split <= 1'b1;
      end else if (w_accept) begin
        r_resp_rd    <= !req_we;
        r_resp_split <= 1'b0;
      end
      if (r_resp_valid) r_hold <= w_resp_data;
    end
  end

  // Split read merge: word lanes >= off come from the captured w0 word, the
  // rest from the w1 word now on the bank output; then rotate back so
  // request lane i = merged lane (i+off)%DATA_BYTES.
  always_comb begin
    w_merge = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      w_merge[8*j +: 8] = w_r_hi[j] ? r_cap[8*j +: 8] : w_bank_rdata[8*j +: 8];
    end
  end

  assign w_rd_rot = DW'(lane_rotate(MAX_BITS'(w_merge), DATA_BYTES, 8,
                                    (DATA_BYTES - int'(r_off)) % DATA_BYTES));

  assign w_resp_data = !r_resp_rd   ? '0 :
                       r_resp_split ? w_rd_rot : w_bank_rdata;

  // Bank output moves on later reads, so between responses the last
  // response word is replayed from r_hold.
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_valid ? w_resp_data : r_hold;

endmodule

// File: tb/tb_byte_sram_ctrl.sv
// tb/tb_byte_sram_ctrl.sv - directed self-checking bench for byte_sram_ctrl

module tb_byte_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  int n_vec;
  int n_err;

  byte_sram_ctrl #(.ADDR_W(16), .DATA_BYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wstrb  (req_wstrb),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call only at a time away from the rising edge.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic rdy1);
    int guard;
    req_we    = we;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = -1;
    rd   = 'x;
    rdy1 = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = req_ready;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        break;
      end
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        rdy1;
  logic [31:0] tp [8];
  int          seen;

  initial begin
    n_vec = 0;
    n_err = 0;
    tp = '{32'h0102_0304, 32'h1111_2222, 32'hCAFE_F00D, 32'h8000_0001,
           32'h5A5A_A5A5, 32'h0000_FFFF, 32'h1357_9BDF, 32'hFEDC_BA98};
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wstrb = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned write/read
    issue(1'b1, 16'h0010, 4'hF, 32'hAABB_CCDD, lat, rd, rdy1);
    chk("al_wr_lat", 32'(lat), 32'd1);
    chk("al_wr_rdata", rd, 32'd0);
    issue(1'b0, 16'h0010, 4'h0, 32'h0, lat, rd, rdy1);
    chk("al_rd_lat", 32'(lat), 32'd1);
    chk("al_rd_data", rd, 32'hAABB_CCDD);
    chk("al_rd_ready", 32'(rdy1), 32'd1);
    issue(1'b0, 16'h0011, 4'h0, 32'h0, lat, rd, rdy1);
    chk("rd11_lat", 32'(lat), 32'd2);
    chk("rd11_lane0", 32'(rd[7:0]), 32'h0000_00CC);

    // Sparse strobe
    issue(1'b1, 16'h0010, 4'b0101, 32'h1122_3344, lat, rd, rdy1);
    issue(1'b0, 16'h0010, 4'h0, 32'h0, lat, rd, rdy1);
    chk("sparse_data", rd, 32'hAA22_CC44);
    repeat (2) @(negedge clk);
    chk("hold_rdata", resp_rdata, 32'hAA22_CC44);
    chk("hold_valid", 32'(resp_valid), 32'd0);

    // Zero strobe write
    issue(1'b1, 16'h0010, 4'h0, 32'hFFFF_FFFF, lat, rd, rdy1);
    chk("zstrb_lat", 32'(lat), 32'd1);
    chk("zstrb_rdata", rd, 32'd0);
    issue(1'b0, 16'h0010, 4'h0, 32'h0, lat, rd, rdy1);
    chk("zstrb_mem", rd, 32'hAA22_CC44);

    // Split write/read
    issue(1'b1, 16'h0023, 4'hF, 32'h0102_0304, lat, rd, rdy1);
    chk("sp_wr_lat", 32'(lat), 32'd2);
    chk("sp_wr_ready", 32'(rdy1), 32'd0);
    issue(1'b0, 16'h0023, 4'h0, 32'h0, lat, rd, rdy1);
    chk("sp_rd_lat", 32'(lat), 32'd2);
    chk("sp_rd_data", rd, 32'h0102_0304);
    issue(1'b0, 16'h0020, 4'h0, 32'h0, lat, rd, rdy1);
    chk("sp_byte23", 32'(rd[31:24]), 32'h0000_0004);
    issue(1'b0, 16'h0024, 4'h0, 32'h0, lat, rd, rdy1);
    chk("sp_bytes24_26", 32'(rd[23:0]), 32'h0001_0203);

    // Address wrap
    issue(1'b1, 16'hFFFE, 4'hF, 32'hDEAD_BEEF, lat, rd, rdy1);
    issue(1'b0, 16'hFFFE, 4'h0, 32'h0, lat, rd, rdy1);
    chk("wrap_rd", rd, 32'hDEAD_BEEF);
    issue(1'b0, 16'h0000, 4'h0, 32'h0, lat, rd, rdy1);
    chk("wrap_low", 32'(rd[15:0]), 32'h0000_DEAD);

    // Read right after write to the same word
    req_we = 1'b1; req_addr = 16'h0040; req_wstrb = 4'hF;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0; req_wstrb = 4'h0;
    @(negedge clk);
    chk("b2b_wr_valid", 32'(resp_valid), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rd_valid", 32'(resp_valid), 32'd1);
    chk("b2b_rd_data", resp_rdata, 32'h1234_5678);

    // Throughput: 8 back-to-back aligned reads
    for (int k = 0; k < 8; k++) begin
      issue(1'b1, 16'(16'h0100 + 4 * k), 4'hF, tp[k], lat, rd, rdy1);
    end
    req_we = 1'b0; req_wstrb = 4'h0; req_addr = 16'h0100; req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k < 7) req_addr = 16'(16'h0100 + 4 * (k + 1));
      else       req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tp_valid%0d", k), 32'(resp_valid), 32'd1);
      chk($sformatf("tp_data%0d", k), resp_rdata, tp[k]);
      chk($sformatf("tp_ready%0d", k), 32'(req_ready), 32'd1);
    end

    // Reset during BEAT2 of a split write
    issue(1'b1, 16'h0020, 4'hF, 32'hA0A1_A2A3, lat, rd, rdy1);
    issue(1'b1, 16'h0024, 4'hF, 32'hB0B1_B2B3, lat, rd, rdy1);
    req_we = 1'b1; req_addr = 16'h0023; req_wstrb = 4'hF;
    req_wdata = 32'h0102_0304; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid_beat2_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("mid_no_resp", 32'(seen), 32'd0);
    chk("mid_ready_after", 32'(req_ready), 32'd1);
    issue(1'b0, 16'h0020, 4'h0, 32'h0, lat, rd, rdy1);
    chk("mid_word20", rd, 32'h04A1_A2A3);
    issue(1'b0, 16'h0024, 4'h0, 32'h0, lat, rd, rdy1);
    chk("mid_word24", rd, 32'hB0B1_B2B3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
